// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//
// Front end for the lab 5 adder / 7-segment display block. It turns raw board
// slide switches and one bouncy pushbutton into two registered operands that
// are entered one after the other.
//
// Ports
//   clk    in   1      system clock, all state updates on the rising edge
//   rst    in   1      asynchronous, active-high reset
//   sw     in   WIDTH  raw slide switches (asynchronous to clk)
//   btn    in   1      raw pushbutton, active-high, asynchronous and bouncy
//   op_a   out  WIDTH  first operand, feeds adder input0
//   op_b   out  WIDTH  second operand, feeds adder input1
//   valid  out  1      both operands hold a completed entry
//   load   out  1      one-cycle pulse in the cycle after any operand capture
//   state  out  2      FSM state for LEDs: 0=WAIT_A, 1=WAIT_B, 2=DONE
//
// Parameters
//   WIDTH      operand width, matches the adder inputs
//   DB_CYCLES  consecutive stable clocks before the debounced level changes
//              (must be 2 or more)
//   CNT_W      debounce counter width, 2**CNT_W must exceed DB_CYCLES
// -----------------------------------------------------------------------------
module operand_loader #(
   parameter int WIDTH     = 3,
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   input  logic             btn,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             valid,
   output logic             load,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      WAIT_A = 2'd0,
      WAIT_B = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   state_t           cur_state;
   state_t           nxt_state;

   logic             btn_meta;
   logic             btn_s;
   logic [WIDTH-1:0] sw_meta;
   logic [WIDTH-1:0] sw_s;

   logic             db;
   logic [CNT_W-1:0] cnt;
   logic             cnt_done;
   logic             press;

   logic [WIDTH-1:0] op_a_nxt;
   logic [WIDTH-1:0] op_b_nxt;
   logic             valid_nxt;

   // --------------------------------------------------------------------------
   // Two-flop synchronisers for the button and every switch bit
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
         sw_meta  <= '0;
         sw_s     <= '0;
      end else begin
         btn_meta <= btn;
         btn_s    <= btn_meta;
         sw_meta  <= sw;
         sw_s     <= sw_meta;
      end
   end

   // --------------------------------------------------------------------------
   // Debounce: the level only moves after DB_CYCLES consecutive clocks that
   // disagree with it; any single agreeing cycle restarts the count.
   // --------------------------------------------------------------------------
   assign cnt_done = (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db  <= 1'b0;
         cnt <= '0;
      end else if (btn_s == db) begin
         cnt <= '0;
      end else if (cnt_done) begin
         db  <= btn_s;
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // The edge on which db flips 0->1. The FSM acts on this same edge, so the
   // capture lines up with the debounced level change rather than one later.
   assign press = ~db & btn_s & cnt_done;

   // --------------------------------------------------------------------------
   // Operand entry FSM: state register plus registered outputs
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= WAIT_A;
         op_a      <= '0;
         op_b      <= '0;
         valid     <= 1'b0;
         load      <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         op_a      <= op_a_nxt;
         op_b      <= op_b_nxt;
         valid     <= valid_nxt;
         load      <= press;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      op_a_nxt  = op_a;
      op_b_nxt  = op_b;
      valid_nxt = valid;
      case (cur_state)
         WAIT_A: begin
            if (press) begin
               op_a_nxt  = sw_s;
               nxt_state = WAIT_B;
            end
         end
         WAIT_B: begin
            if (press) begin
               op_b_nxt  = sw_s;
               valid_nxt = 1'b1;
               nxt_state = DONE;
            end
         end
         DONE: begin
            // A press here starts a fresh entry: the new value becomes op_a
            // directly, so no separate clear press is needed.
            if (press) begin
               op_a_nxt  = sw_s;
               op_b_nxt  = '0;
               valid_nxt = 1'b0;
               nxt_state = WAIT_B;
            end
         end
         default: begin
            // Unused encoding 3 falls back to WAIT_A on the next clock.
            nxt_state = WAIT_A;
         end
      endcase
   end

   assign state = cur_state;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

   localparam int WIDTH = 3;
   localparam int DB    = 4;
   localparam int CW    = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] sw;
   logic             btn;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             valid;
   logic             load;
   logic [1:0]       state;

   operand_loader #(
      .WIDTH     (WIDTH),
      .DB_CYCLES (DB),
      .CNT_W     (CW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sw    (sw),
      .btn   (btn),
      .op_a  (op_a),
      .op_b  (op_b),
      .valid (valid),
      .load  (load),
      .state (state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             v;
      logic [1:0]       st;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int load_count = 0;
   int last_load_cyc = -1;
   logic load_prev = 1'b0;

   // reference model of the entry FSM
   logic [WIDTH-1:0] m_a = '0;
   logic [WIDTH-1:0] m_b = '0;
   logic             m_v = 1'b0;
   logic [1:0]       m_st = 2'd0;

   always @(posedge clk) cyc++;

   // scoreboard consumer: every load pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && load) begin
         load_count++;
         last_load_cyc = cyc;
         checks++;
         if (load_prev) begin
            errors++;
            $display("FAIL load_double: load high two cycles running at cyc %0d, required single pulse", cyc);
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_load: load=1 at cyc %0d, required no capture", cyc);
         end else begin
            e = sb.pop_front();
            if ({op_a, op_b, valid, state} !== {e.a, e.b, e.v, e.st})
               begin
                  errors++;
                  $display("FAIL capture: got a=%0d b=%0d v=%0b st=%0d, required a=%0d b=%0d v=%0b st=%0d",
                           op_a, op_b, valid, state, e.a, e.b, e.v, e.st);
               end
         end
      end
      load_prev = load && !rst;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic model_press(input logic [WIDTH-1:0] s);
      case (m_st)
         2'd0: begin m_a = s; m_st = 2'd1; end
         2'd1: begin m_b = s; m_v = 1'b1; m_st = 2'd2; end
         default: begin m_a = s; m_b = '0; m_v = 1'b0; m_st = 2'd1; end
      endcase
      sb.push_back('{a: m_a, b: m_b, v: m_v, st: m_st});
   endtask

   // btn high for 'hold' sampled edges, then low for 'low' cycles; optionally
   // changes sw after hold-cycle index chg_i. c0 is the cycle count at drive.
   task automatic press(input int hold, input int low, input int chg_i,
                        input logic [WIDTH-1:0] chg_v, output int c0);
      step();
      c0 = cyc;
      btn = 1'b1;
      for (int i = 0; i < hold; i++) begin
         step();
         if (i == chg_i) sw = chg_v;
      end
      btn = 1'b0;
      repeat (low) step();
   endtask

   task automatic set_sw(input logic [WIDTH-1:0] v);
      sw = v;
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn = 1'b0;
      sw  = '0;
      repeat (3) step();
      checks++;
      if ({op_a, op_b, valid, load, state} !== '0) begin
         errors++;
         $display("FAIL reset_hold: got a=%0d b=%0d v=%0b l=%0b st=%0d, required all 0",
                  op_a, op_b, valid, load, state);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if ({op_a, op_b, valid, load, state} !== '0) begin
            errors++;
            $display("FAIL reset_idle: cycle %0d got a=%0d b=%0d v=%0b l=%0b st=%0d, required all 0",
                     i, op_a, op_b, valid, load, state);
         end
      end
   endtask

   task automatic test_two_operand();
      int c0;
      int l0;
      set_sw(3'd5);
      l0 = load_count;
      model_press(3'd5);
      press(10, 10, -1, '0, c0);
      checks++;
      if (last_load_cyc !== c0 + DB + 2) begin
         errors++;
         $display("FAIL latency_a: load at cyc %0d, required %0d", last_load_cyc, c0 + DB + 2);
      end
      checks++;
      if (load_count - l0 !== 1 || op_a !== 3'd5 || state !== 2'd1) begin
         errors++;
         $display("FAIL entry_a: loads=%0d a=%0d st=%0d, required loads=1 a=5 st=1",
                  load_count - l0, op_a, state);
      end
      set_sw(3'd3);
      model_press(3'd3);
      press(10, 10, -1, '0, c0);
      checks++;
      if (last_load_cyc !== c0 + DB + 2) begin
         errors++;
         $display("FAIL latency_b: load at cyc %0d, required %0d", last_load_cyc, c0 + DB + 2);
      end
      checks++;
      if (op_b !== 3'd3 || valid !== 1'b1 || state !== 2'd2 || ({1'b0, op_a} + {1'b0, op_b}) !== 4'd8) begin
         errors++;
         $display("FAIL entry_b: a=%0d b=%0d v=%0b st=%0d, required b=3 v=1 st=2 sum=8",
                  op_a, op_b, valid, state);
      end
   endtask

   task automatic test_bounce();
      logic [8:0] pat;
      int l0;
      pat = 9'b0_1110_1101;   // applied LSB first: 1,0,1,1,0,1,1,1,0
      l0 = load_count;
      for (int i = 0; i < 9; i++) begin
         step();
         btn = pat[i];
      end
      step();
      btn = 1'b0;
      repeat (15) step();
      checks++;
      if (load_count !== l0) begin
         errors++;
         $display("FAIL bounce_load: %0d load pulses, required 0", load_count - l0);
      end
      checks++;
      if ({op_a, op_b, valid, state} !== {m_a, m_b, m_v, m_st}) begin
         errors++;
         $display("FAIL bounce_hold: a=%0d b=%0d v=%0b st=%0d, required a=%0d b=%0d v=%0b st=%0d",
                  op_a, op_b, valid, state, m_a, m_b, m_v, m_st);
      end
   endtask

   task automatic test_long_hold();
      int c0;
      int l0;
      set_sw(3'd7);
      l0 = load_count;
      model_press(3'd7);
      press(200, 10, -1, '0, c0);
      checks++;
      if (load_count - l0 !== 1) begin
         errors++;
         $display("FAIL long_hold_count: %0d load pulses, required 1", load_count - l0);
      end
      checks++;
      if (op_a !== 3'd7 || op_b !== 3'd0 || valid !== 1'b0 || state !== 2'd1) begin
         errors++;
         $display("FAIL long_hold_state: a=%0d b=%0d v=%0b st=%0d, required a=7 b=0 v=0 st=1",
                  op_a, op_b, valid, state);
      end
   endtask

   task automatic test_reentry();
      int c0;
      model_press(3'd7);
      press(10, 10, -1, '0, c0);
      checks++;
      if (op_a !== 3'd7 || op_b !== 3'd7 || valid !== 1'b1 || state !== 2'd2) begin
         errors++;
         $display("FAIL reentry_setup: a=%0d b=%0d v=%0b st=%0d, required a=7 b=7 v=1 st=2",
                  op_a, op_b, valid, state);
      end
      set_sw(3'd2);
      model_press(3'd2);
      press(10, 10, -1, '0, c0);
      checks++;
      if (op_a !== 3'd2 || op_b !== 3'd0 || valid !== 1'b0 || state !== 2'd1) begin
         errors++;
         $display("FAIL reentry: a=%0d b=%0d v=%0b st=%0d, required a=2 b=0 v=0 st=1",
                  op_a, op_b, valid, state);
      end
   endtask

   task automatic test_async_reset();
      int r0;
      set_sw(3'd6);
      step();
      btn = 1'b1;
      repeat (3) step();        // debounce count under way in WAIT_B
      rst = 1'b1;
      #1;
      checks++;
      if ({op_a, op_b, valid, load, state} !== '0) begin
         errors++;
         $display("FAIL async_reset: a=%0d b=%0d v=%0b l=%0b st=%0d, required all 0 before any edge",
                  op_a, op_b, valid, load, state);
      end
      m_a = '0; m_b = '0; m_v = 1'b0; m_st = 2'd0;
      #2;
      rst = 1'b0;
      r0 = cyc;
      // btn still held: a capture needs a completely fresh sync + debounce
      model_press(3'd6);
      for (int i = 1; i <= DB + 1; i++) begin
         step();
         checks++;
         if (load !== 1'b0 || state !== 2'd0 || op_a !== 3'd0) begin
            errors++;
            $display("FAIL reset_press_lost: edge %0d after release l=%0b st=%0d a=%0d, required 0 0 0",
                     i, load, state, op_a);
         end
      end
      step();
      checks++;
      if (last_load_cyc !== r0 + DB + 2 || op_a !== 3'd6 || state !== 2'd1) begin
         errors++;
         $display("FAIL reset_fresh: load cyc %0d a=%0d st=%0d, required cyc %0d a=6 st=1",
                  last_load_cyc, op_a, state, r0 + DB + 2);
      end
      btn = 1'b0;
      repeat (10) step();
   endtask

   task automatic test_sw_change();
      int c0;
      set_sw(3'd4);
      model_press(3'd4);
      // sw moves just before the capture edge; the synchronised value is kept
      press(10, 10, DB, 3'd1, c0);
      checks++;
      if (op_b !== 3'd4 || valid !== 1'b1 || state !== 2'd2 ||
          ({1'b0, op_a} + {1'b0, op_b}) !== 4'd10) begin
         errors++;
         $display("FAIL sw_change: a=%0d b=%0d v=%0b st=%0d, required a=6 b=4 v=1 st=2",
                  op_a, op_b, valid, state);
      end
   endtask

   initial begin
      rst = 1'b1;
      btn = 1'b0;
      sw  = '0;
      test_reset();
      test_two_operand();
      test_bounce();
      test_long_hold();
      test_reentry();
      test_async_reset();
      test_sw_change();
      repeat (5) step();
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL pending: %0d expected captures never seen, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
